// File: rtl/ram_test_engine.sv
// Multi-channel SDRAM pattern tester driving one Avalon-MM master per channel.
// Optional first-error capture is enabled by defining RAM_TEST_ERR_LOG_EN.
module ram_test_engine #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LAST_ADDR = (2 ** ADDR_W) - 1,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned BLINK_W   = 24
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          continuous,
    input  logic [DATA_W-1:0]                             seed,
    output logic                                          busy,
    output logic                                          done,
    output logic [15:0]                                   pass_cnt,
    output logic [15:0]                                   err_cnt,
    output logic [NUM_CH-1:0]                             fail_ch_mask,
    output logic                                          led,
    output logic [NUM_CH*ADDR_W-1:0]                      avm_address,
    output logic [NUM_CH-1:0]                             avm_write,
    output logic [NUM_CH-1:0]                             avm_read,
    output logic [NUM_CH*DATA_W-1:0]                      avm_writedata,
    output logic [NUM_CH*DATA_W/8-1:0]                    avm_byteenable,
    input  logic [NUM_CH*DATA_W-1:0]                      avm_readdata,
    input  logic [NUM_CH-1:0]                             avm_readdatavalid,
    input  logic [NUM_CH-1:0]                             avm_waitrequest,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0]  err_ch,
    output logic [ADDR_W-1:0]                             err_addr,
    output logic [DATA_W-1:0]                             err_exp,
    output logic [DATA_W-1:0]                             err_act
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              skip_q, skip_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              cont_q, cont_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic [15:0]       pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic [NUM_CH-1:0] fail_q, fail_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              led_q, led_d;
    logic [NUM_CH-1:0] write_q, write_d;
    logic [NUM_CH-1:0] read_q, read_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              start_go;
    logic              err_hit;
    logic [DATA_W-1:0] hit_act;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] rd_data;
    logic              last_addr;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic ph);
        logic [DATA_W-1:0] p;
        p = s ^ DATA_W'(a);
        return ph ? ~p : p;
    endfunction

    // Sequencer: channel, phase and address walk plus timeout and error counting.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        addr_d   = addr_q;
        phase_d  = phase_q;
        skip_d   = skip_q;
        seed_d   = seed_q;
        cont_d   = cont_q;
        wait_d   = '0;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        blink_d  = blink_q;
        start_go = 1'b0;
        err_hit  = 1'b0;
        hit_act  = '0;
        exp_data = pattern(seed_q, addr_q, phase_q);
        rd_data  = avm_readdata[ch_q*DATA_W +: DATA_W];
        last_addr = (addr_q == ADDR_W'(LAST_ADDR));

        if (state_q != S_IDLE && state_q != S_DONE) begin
            blink_d = blink_q + BLINK_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_go = 1'b1;
                    state_d  = S_WR;
                    ch_d     = '0;
                    addr_d   = '0;
                    phase_d  = 1'b0;
                    skip_d   = 1'b0;
                    seed_d   = seed;
                    cont_d   = continuous;
                    pass_d   = '0;
                    err_d    = '0;
                    fail_d   = '0;
                    blink_d  = '0;
                end
            end
            S_WR: begin
                if (!avm_waitrequest[ch_q]) begin
                    if (last_addr) begin
                        addr_d  = '0;
                        state_d = S_RD_REQ;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (wait_q == TO_W'(TIMEOUT)) begin
                    err_hit = 1'b1;
                    skip_d  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            S_RD_REQ: begin
                if (!avm_waitrequest[ch_q]) begin
                    state_d = S_RD_WAIT;
                end else if (wait_q == TO_W'(TIMEOUT)) begin
                    err_hit = 1'b1;
                    skip_d  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid[ch_q]) begin
                    if (rd_data != exp_data) begin
                        err_hit = 1'b1;
                        hit_act = rd_data;
                    end
                    if (last_addr) begin
                        state_d = S_NEXT;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_RD_REQ;
                    end
                end else if (wait_q == TO_W'(TIMEOUT)) begin
                    err_hit = 1'b1;
                    skip_d  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            S_NEXT: begin
                addr_d  = '0;
                state_d = S_WR;
                if (!skip_q && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    skip_d  = 1'b0;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        ch_d = '0;
                        if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
                        if (!cont_q) state_d = S_DONE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_hit) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            fail_d[ch_q] = 1'b1;
        end

        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        write_d = '0;
        read_d  = '0;
        if (state_d == S_WR)     write_d[ch_d] = 1'b1;
        if (state_d == S_RD_REQ) read_d[ch_d]  = 1'b1;
        wdata_d = pattern(seed_d, addr_d, phase_d);
        led_d   = (|fail_d) ? 1'b1 : (busy_d ? blink_d[BLINK_W-1] : 1'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            skip_q  <= 1'b0;
            seed_q  <= '0;
            cont_q  <= 1'b0;
            wait_q  <= '0;
            pass_q  <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            blink_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= 1'b0;
            write_q <= '0;
            read_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            skip_q  <= skip_d;
            seed_q  <= seed_d;
            cont_q  <= cont_d;
            wait_q  <= wait_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            blink_q <= blink_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            led_q   <= led_d;
            write_q <= write_d;
            read_q  <= read_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign err_cnt        = err_q;
    assign fail_ch_mask   = fail_q;
    assign led            = led_q;
    assign avm_write      = write_q;
    assign avm_read       = read_q;
    assign avm_address    = {NUM_CH{addr_q}};
    assign avm_writedata  = {NUM_CH{wdata_q}};
    assign avm_byteenable = '1;

`ifdef RAM_TEST_ERR_LOG_EN
    logic              seen_q, seen_d;
    logic [CH_W-1:0]   cap_ch_q, cap_ch_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0] cap_exp_q, cap_exp_d;
    logic [DATA_W-1:0] cap_act_q, cap_act_d;

    // First error after start is frozen until the next start; timeouts record act=0.
    always_comb begin
        seen_d     = seen_q;
        cap_ch_d   = cap_ch_q;
        cap_addr_d = cap_addr_q;
        cap_exp_d  = cap_exp_q;
        cap_act_d  = cap_act_q;
        if (start_go) begin
            seen_d     = 1'b0;
            cap_ch_d   = '0;
            cap_addr_d = '0;
            cap_exp_d  = '0;
            cap_act_d  = '0;
        end else if (err_hit && !seen_q) begin
            seen_d     = 1'b1;
            cap_ch_d   = ch_q;
            cap_addr_d = addr_q;
            cap_exp_d  = exp_data;
            cap_act_d  = hit_act;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q     <= 1'b0;
            cap_ch_q   <= '0;
            cap_addr_q <= '0;
            cap_exp_q  <= '0;
            cap_act_q  <= '0;
        end else begin
            seen_q     <= seen_d;
            cap_ch_q   <= cap_ch_d;
            cap_addr_q <= cap_addr_d;
            cap_exp_q  <= cap_exp_d;
            cap_act_q  <= cap_act_d;
        end
    end

    assign err_ch   = cap_ch_q;
    assign err_addr = cap_addr_q;
    assign err_exp  = cap_exp_q;
    assign err_act  = cap_act_q;
`else
    logic unused_log;
    assign unused_log = ^{start_go, hit_act};
    assign err_ch   = '0;
    assign err_addr = '0;
    assign err_exp  = '0;
    assign err_act  = '0;
`endif

endmodule

// File: tb/tb_ram_test_engine.sv
// Scoreboard bench for ram_test_engine: expected transfers queued at start, checked on acceptance.
module tb_ram_test_engine;

    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, start, continuous;
    logic [DW-1:0]       seed;
    logic                busy, done, led;
    logic [15:0]         pass_cnt, err_cnt;
    logic [NCH-1:0]      fail_ch_mask;
    logic [NCH*AW-1:0]   avm_address;
    logic [NCH-1:0]      avm_write, avm_read;
    logic [NCH*DW-1:0]   avm_writedata;
    logic [NCH*DW/8-1:0] avm_byteenable;
    logic [NCH*DW-1:0]   avm_readdata;
    logic [NCH-1:0]      avm_readdatavalid, avm_waitrequest;
    logic [0:0]          err_ch;
    logic [AW-1:0]       err_addr;
    logic [DW-1:0]       err_exp, err_act;

    ram_test_engine #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(15), .TIMEOUT(15), .BLINK_W(6)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .seed(seed),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .fail_ch_mask(fail_ch_mask), .led(led),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest),
        .err_ch(err_ch), .err_addr(err_addr), .err_exp(err_exp), .err_act(err_act)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [63:0] exp_q[$];
    logic [31:0] mem[NCH][16];
    bit          stall_mode, stuck_mode, nordv_mode;
    int          rd_cnt[NCH];
    logic [3:0]  rd_addr[NCH];
    logic [31:0] rd_exp[NCH];
    int          stall[NCH];
    bit          prev_wait[NCH];
    logic [5:0]  prev_req[NCH];
    int          exp_err;
    bit          first_seen;
    logic [63:0] first_ch, first_addr, first_exp, first_act;

    function automatic logic [31:0] pat(input logic [31:0] s, input int a, input bit ph);
        logic [31:0] p;
        p = s ^ 32'(a);
        return ph ? ~p : p;
    endfunction

    function automatic logic [63:0] pack(input bit wr, input int ch, input int a, input logic [31:0] d);
        return {8'(wr), 8'(ch), 16'(a), d};
    endfunction

    task automatic push_run(input logic [31:0] s, input bit to0);
        for (int ch = 0; ch < int'(NCH); ch++) begin
            for (int ph = 0; ph < 2; ph++) begin
                if (to0 && ch == 0 && ph == 1) continue;
                for (int a = 0; a < 16; a++) exp_q.push_back(pack(1'b1, ch, a, pat(s, a, ph[0])));
                if (to0 && ch == 0) exp_q.push_back(pack(1'b0, 0, 0, pat(s, 0, 1'b0)));
                else for (int a = 0; a < 16; a++) exp_q.push_back(pack(1'b0, ch, a, pat(s, a, ph[0])));
            end
        end
    endtask

    // Memory responder: plans waitrequest/readdatavalid at negedge for the next posedge.
    initial begin : responder
        logic        wr, rd;
        logic [3:0]  a;
        logic [31:0] wd;
        logic [63:0] e, got;
        avm_waitrequest   = '0;
        avm_readdatavalid = '0;
        avm_readdata      = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            rd_cnt[c] = 0; stall[c] = -1; prev_wait[c] = 1'b0; prev_req[c] = '0;
        end
        forever begin
            @(negedge clk);
            if ((avm_write | avm_read) != '0)
                chk("one_req", 64'($countones(avm_write | avm_read)), 64'd1);
            for (int c = 0; c < int'(NCH); c++) begin
                avm_readdatavalid[c] = 1'b0;
                if (rd_cnt[c] > 0) begin
                    rd_cnt[c]--;
                    if (rd_cnt[c] == 0 && !(nordv_mode && c == 0)) begin
                        avm_readdatavalid[c] = 1'b1;
                        avm_readdata[c*DW +: DW] = mem[c][rd_addr[c]];
                        if (mem[c][rd_addr[c]] != rd_exp[c]) begin
                            exp_err++;
                            if (!first_seen) begin
                                first_seen = 1'b1;
                                first_ch   = 64'(c);
                                first_addr = 64'(rd_addr[c]);
                                first_exp  = 64'(rd_exp[c]);
                                first_act  = 64'(mem[c][rd_addr[c]]);
                            end
                        end
                    end
                end
                wr = avm_write[c];
                rd = avm_read[c];
                a  = avm_address[c*AW +: AW];
                wd = avm_writedata[c*DW +: DW];
                if (prev_wait[c]) chk("req_hold", 64'({wr, rd, a}), 64'(prev_req[c]));
                if (wr || rd) begin
                    if (stall[c] < 0) stall[c] = stall_mode ? int'($urandom_range(0, 5)) : 0;
                    if (stall[c] > 0) begin
                        avm_waitrequest[c] = 1'b1;
                        stall[c]--;
                    end else begin
                        avm_waitrequest[c] = 1'b0;
                        stall[c] = -1;
                        got = pack(wr, c, int'(a), wr ? wd : 32'd0);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_xfer", got, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            if (wr) begin
                                chk("wr_xfer", got, e);
                                mem[c][a] = (stuck_mode && c == 1) ? (wd & ~32'h8) : wd;
                            end else begin
                                chk("rd_xfer", got[63:32], e[63:32]);
                                rd_cnt[c]  = 2;
                                rd_addr[c] = a;
                                rd_exp[c]  = e[31:0];
                            end
                        end
                    end
                end else begin
                    avm_waitrequest[c] = 1'b0;
                    stall[c] = -1;
                end
                prev_wait[c] = avm_waitrequest[c] && (wr || rd);
                prev_req[c]  = {wr, rd, a};
            end
        end
    end

    task automatic check_zero(input string t);
        chk({t, "_busy"}, 64'(busy), 64'd0);
        chk({t, "_done"}, 64'(done), 64'd0);
        chk({t, "_pass"}, 64'(pass_cnt), 64'd0);
        chk({t, "_err"}, 64'(err_cnt), 64'd0);
        chk({t, "_fail"}, 64'(fail_ch_mask), 64'd0);
        chk({t, "_led"}, 64'(led), 64'd0);
        chk({t, "_req"}, 64'({avm_write, avm_read}), 64'd0);
        chk({t, "_errlog"}, 64'({err_ch, err_addr, err_exp, err_act}), 64'd0);
    endtask

    task automatic run(input logic [31:0] s, input bit cont);
        exp_err    = 0;
        first_seen = 1'b0;
        @(negedge clk);
        seed       = s;
        continuous = cont;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string t);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({t, "_done"}, 64'(done), 64'd1);
        chk({t, "_busy"}, 64'(busy), 64'd0);
        chk({t, "_q_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : main
        logic [31:0] s;
        int          n;
        bit          found;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; seed = '0;
        stall_mode = 1'b0; stuck_mode = 1'b0; nordv_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Ideal memory, single pass
        s = 32'hA5A5_0000;
        push_run(s, 1'b0);
        run(s, 1'b0);
        wait_done("ideal");
        chk("ideal_err", 64'(err_cnt), 64'd0);
        chk("ideal_pass", 64'(pass_cnt), 64'd1);
        chk("ideal_fail", 64'(fail_ch_mask), 64'd0);
        chk("ideal_led", 64'(led), 64'd0);

        // Channel 1 data bit 3 stuck at 0
        stuck_mode = 1'b1;
        push_run(32'd0, 1'b0);
        run(32'd0, 1'b0);
        wait_done("stuck");
        chk("stuck_err", 64'(err_cnt), 64'(exp_err));
        chk("stuck_fail", 64'(fail_ch_mask), 64'd2);
        chk("stuck_pass", 64'(pass_cnt), 64'd1);
        chk("stuck_led", 64'(led), 64'd1);
`ifdef RAM_TEST_ERR_LOG_EN
        chk("stuck_err_ch", 64'(err_ch), first_ch);
        chk("stuck_err_addr", 64'(err_addr), first_addr);
        chk("stuck_err_exp", 64'(err_exp), first_exp);
        chk("stuck_err_act", 64'(err_act), first_act);
`else
        chk("stuck_errlog", 64'({err_ch, err_addr, err_exp, err_act}), 64'd0);
`endif
        stuck_mode = 1'b0;

        // Random waitrequest stalls
        stall_mode = 1'b1;
        s = $urandom;
        push_run(s, 1'b0);
        run(s, 1'b0);
        wait_done("stall");
        chk("stall_err", 64'(err_cnt), 64'd0);
        chk("stall_pass", 64'(pass_cnt), 64'd1);
        chk("stall_fail", 64'(fail_ch_mask), 64'd0);
        stall_mode = 1'b0;

        // Channel 0 never returns read data
        nordv_mode = 1'b1;
        s = 32'h1234_5670;
        push_run(s, 1'b1);
        run(s, 1'b1 ^ 1'b1);
        wait_done("tmo");
        chk("tmo_err", 64'(err_cnt), 64'd1);
        chk("tmo_fail", 64'(fail_ch_mask), 64'd1);
        chk("tmo_pass", 64'(pass_cnt), 64'd1);
`ifdef RAM_TEST_ERR_LOG_EN
        chk("tmo_errlog", 64'({err_ch, err_addr}), 64'd0);
        chk("tmo_err_exp", 64'(err_exp), 64'(pat(s, 0, 1'b0)));
        chk("tmo_err_act", 64'(err_act), 64'd0);
`endif
        nordv_mode = 1'b0;

        // Continuous run, reset mid-write on channel 1 at address 7
        s = 32'h0F0F_3C3C;
        for (int k = 0; k < 4; k++) push_run(s, 1'b0);
        run(s, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            n = 0;
            while (pass_cnt < 16'(k) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("cont_pass", 64'(pass_cnt), 64'(k));
        end
        n = 0;
        found = 1'b0;
        while (!found && n < 3000) begin
            @(negedge clk);
            n++;
            found = avm_write[1] && (avm_address[AW +: AW] == 4'd7);
        end
        chk("cont_reach_a7", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < int'(NCH); c++) begin
            rd_cnt[c] = 0; stall[c] = -1; prev_wait[c] = 1'b0;
        end

        // start while busy must not restart or relatch seed
        s = 32'hDEAD_BEE0;
        push_run(s, 1'b0);
        run(s, 1'b0);
        repeat (40) @(negedge clk);
        chk("rebusy_busy", 64'(busy), 64'd1);
        seed       = 32'h0000_FFFF;
        continuous = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done("rebusy");
        chk("rebusy_pass", 64'(pass_cnt), 64'd1);
        chk("rebusy_err", 64'(err_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
